// File: rtl/fir_pkg.sv
// Constants and rounding/clip arithmetic shared by the 211-tap FIR filter,
// its output requantizer and their testbenches.
package fir_pkg;

  localparam int FIR_ACC_WIDTH = 40;
  localparam int FIR_OUT_WIDTH = 16;

  localparam logic signed [FIR_ACC_WIDTH:0] FIR_Q_MAX = (41'sd1 <<< (FIR_OUT_WIDTH - 1)) - 41'sd1;
  localparam logic signed [FIR_ACC_WIDTH:0] FIR_Q_MIN = -(41'sd1 <<< (FIR_OUT_WIDTH - 1));

  typedef struct packed {
    logic                            sat;
    logic signed [FIR_OUT_WIDTH-1:0] data;
  } fir_sample_t;

  // Round half-up at one extra bit of headroom, arithmetic shift, then clip.
  function automatic fir_sample_t sat_round(input logic signed [FIR_ACC_WIDTH-1:0] acc,
                                            input int unsigned shift);
    logic        [FIR_ACC_WIDTH:0] one;
    logic signed [FIR_ACC_WIDTH:0] r;
    logic signed [FIR_ACC_WIDTH:0] q;
    fir_sample_t                   res;
    one = 1;
    r   = $signed({acc[FIR_ACC_WIDTH-1], acc}) + $signed((one << shift) >> 1);
    q   = r >>> shift;
    res.sat = 1'b1;
    if (q > FIR_Q_MAX)      res.data = FIR_Q_MAX[FIR_OUT_WIDTH-1:0];
    else if (q < FIR_Q_MIN) res.data = FIR_Q_MIN[FIR_OUT_WIDTH-1:0];
    else begin
      res.sat  = 1'b0;
      res.data = q[FIR_OUT_WIDTH-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_output_requantizer_if.sv
// Filter-side strobe input and consumer-side valid/ready output of the requantizer.
interface fir_output_requantizer_if #(
  parameter int ACC_WIDTH = fir_pkg::FIR_ACC_WIDTH,
  parameter int OUT_WIDTH = fir_pkg::FIR_OUT_WIDTH
) ();

  logic signed [ACC_WIDTH-1:0] in_data;
  logic                        in_valid;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid
  );

endinterface

// File: rtl/fir_sync_fifo.sv
// Small synchronous FIFO with combinational head read; the head value is held
// once the buffer drains so the output does not wander over stale slots.
module fir_sync_fifo import fir_pkg::*; #(
  parameter  int WIDTH = FIR_OUT_WIDTH,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] hold_q, hold_d;

  assign level    = wr_ptr_q - rd_ptr_q;
  assign full     = (level == LW'(DEPTH));
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign pop_data = empty ? hold_q : mem_q[rd_ptr_q[AW-1:0]];

  // A push while full is legal only alongside a pop; the caller gates it.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    hold_d   = hold_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop && !empty) begin
      hold_d   = mem_q[rd_ptr_q[AW-1:0]];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hold_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      hold_q   <= hold_d;
    end
  end

endmodule

// File: rtl/fir_output_requantizer.sv
// FIR output stage: round, shift, saturate, then buffer for a stalling consumer.
// Define FIR_REQUANT_STATS_EN to add clr_stats / sat_count / drop_count.
module fir_output_requantizer import fir_pkg::*; #(
  parameter  int ACC_WIDTH  = FIR_ACC_WIDTH,
  parameter  int OUT_WIDTH  = FIR_OUT_WIDTH,
  parameter  int SHIFT      = 15,
  parameter  int FIFO_DEPTH = 4,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fir_output_requantizer_if.slave  io,
  output logic [LVL_W-1:0]         fifo_level,
  output logic                     sat_flag,
  output logic                     drop_flag
`ifdef FIR_REQUANT_STATS_EN
  ,
  input  logic                     clr_stats,
  output logic [15:0]              sat_count,
  output logic [15:0]              drop_count
`endif
);

  localparam int RW = ACC_WIDTH + 1;
  localparam logic        [RW-1:0] ONE   = RW'(1);
  localparam logic signed [RW-1:0] RND   = $signed((ONE << SHIFT) >> 1);
  localparam logic signed [RW-1:0] Q_MAX = $signed({{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [RW-1:0] Q_MIN = $signed({{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

  // vld_pipe_q[0]: S1 holds a sample, vld_pipe_q[1]: S2 holds a sample.
  logic [1:0]                  vld_pipe_q, vld_pipe_d;
  logic signed [RW-1:0]        s1_acc_q, s1_acc_d;
  logic signed [RW-1:0]        s2_scaled;
  logic signed [OUT_WIDTH-1:0] s2_data_q, s2_data_d;
  logic                        s2_sat_q, s2_sat_d;

  logic fifo_full, fifo_empty, push, pop;

  always_comb begin
    vld_pipe_d = {vld_pipe_q[0], io.in_valid};
    s1_acc_d   = s1_acc_q;
    if (io.in_valid) s1_acc_d = $signed({io.in_data[ACC_WIDTH-1], io.in_data}) + RND;

    s2_scaled = s1_acc_q >>> SHIFT;
    s2_data_d = s2_data_q;
    s2_sat_d  = s2_sat_q;
    if (vld_pipe_q[0]) begin
      s2_sat_d = 1'b1;
      if (s2_scaled > Q_MAX)      s2_data_d = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      else if (s2_scaled < Q_MIN) s2_data_d = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      else begin
        s2_sat_d  = 1'b0;
        s2_data_d = s2_scaled[OUT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_acc_q   <= '0;
      s2_data_q  <= '0;
      s2_sat_q   <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_acc_q   <= s1_acc_d;
      s2_data_q  <= s2_data_d;
      s2_sat_q   <= s2_sat_d;
    end
  end

  // A full buffer still accepts when the consumer frees the head this cycle.
  assign pop       = io.out_valid & io.out_ready;
  assign push      = vld_pipe_q[1] & (~fifo_full | pop);
  assign sat_flag  = vld_pipe_q[1] & s2_sat_q;
  assign drop_flag = vld_pipe_q[1] & fifo_full & ~pop;

  assign io.out_valid = ~fifo_empty;

  fir_sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (s2_data_q),
    .pop       (pop),
    .pop_data  (io.out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

`ifdef FIR_REQUANT_STATS_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    sat_cnt_d  = sat_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_stats) begin
      sat_cnt_d  = '0;
      drop_cnt_d = '0;
    end else begin
      if (sat_flag && sat_cnt_q != 16'hFFFF)   sat_cnt_d  = sat_cnt_q + 16'd1;
      if (drop_flag && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      sat_cnt_q  <= sat_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign sat_count  = sat_cnt_q;
  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fir_output_requantizer.sv
// Bench for fir_output_requantizer: directed scenarios plus random traffic,
// all checked every cycle against a queue-based model of the block.
module tb_fir_output_requantizer;
  import fir_pkg::*;

  localparam int AW    = 40;
  localparam int OW    = 16;
  localparam int SH    = 15;
  localparam int DEPTH = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] fifo_level;
  logic       sat_flag, drop_flag;
`ifdef FIR_REQUANT_STATS_EN
  logic        clr_stats = 1'b0;
  logic [15:0] sat_count, drop_count;
`endif

  always #5 clk = ~clk;

  fir_output_requantizer_if #(.ACC_WIDTH(AW), .OUT_WIDTH(OW)) io ();

  fir_output_requantizer #(
    .ACC_WIDTH (AW), .OUT_WIDTH (OW), .SHIFT (SH), .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io         (io),
    .fifo_level (fifo_level),
    .sat_flag   (sat_flag),
    .drop_flag  (drop_flag)
`ifdef FIR_REQUANT_STATS_EN
    ,
    .clr_stats  (clr_stats),
    .sat_count  (sat_count),
    .drop_count (drop_count)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference arithmetic: exact integer rounding half-up, then clip to OW bits.
  function automatic void requant(input longint x, output longint q, output bit s);
    longint mx, mn;
    mx = (64'sd1 <<< (OW - 1)) - 1;
    mn = -mx - 1;
    q  = (x + (64'sd1 <<< (SH - 1))) >>> SH;
    s  = 1'b0;
    if (q > mx) begin q = mx; s = 1'b1; end
    if (q < mn) begin q = mn; s = 1'b1; end
  endfunction

  typedef struct { int e; longint d; bit s; } sch_t;
  sch_t   sch[$];
  longint mq[$];
  longint got[$];
  int     m_sat = 0, m_drop = 0;
  int     sat_seen = 0, drop_seen = 0;

  // Model: inputs sampled in cycle c are written (or dropped) at edge c+3.
  always @(negedge clk) begin
    bit     wr, ws, full0, pop, s;
    longint q;
    if (!rst_n) begin
      sch.delete();
      mq.delete();
      m_sat  = 0;
      m_drop = 0;
      chk("rst_out_valid", io.out_valid, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_sat_flag", sat_flag, 0);
      chk("rst_drop_flag", drop_flag, 0);
`ifdef FIR_REQUANT_STATS_EN
      chk("rst_sat_count", sat_count, 0);
      chk("rst_drop_count", drop_count, 0);
`endif
    end else begin
      chk("out_valid", io.out_valid, mq.size() > 0);
      chk("fifo_level", fifo_level, mq.size());
      if (mq.size() > 0) chk("out_data", io.out_data, mq[0]);
      wr    = sch.size() > 0 && sch[0].e == cyc + 1;
      ws    = wr && sch[0].s;
      full0 = mq.size() == DEPTH;
      pop   = mq.size() > 0 && io.out_ready;
      chk("sat_flag", sat_flag, ws);
      chk("drop_flag", drop_flag, wr && full0 && !pop);
`ifdef FIR_REQUANT_STATS_EN
      chk("sat_count", sat_count, m_sat);
      chk("drop_count", drop_count, m_drop);
`endif
      if (io.out_valid && io.out_ready) got.push_back(io.out_data);
      if (sat_flag) sat_seen++;
      if (drop_flag) drop_seen++;

`ifdef FIR_REQUANT_STATS_EN
      if (clr_stats) begin
        m_sat = 0;
        m_drop = 0;
      end else begin
        if (ws && m_sat < 65535) m_sat++;
        if (wr && full0 && !pop && m_drop < 65535) m_drop++;
      end
`endif
      if (pop) void'(mq.pop_front());
      if (wr) begin
        if (!full0 || pop) mq.push_back(sch[0].d);
        void'(sch.pop_front());
      end
      if (io.in_valid) begin
        requant(longint'(io.in_data), q, s);
        sch.push_back('{e: cyc + 3, d: q, s: s});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input longint x);
    io.in_valid = 1'b1;
    io.in_data  = x[AW-1:0];
    tick();
    io.in_valid = 1'b0;
  endtask

  task automatic wait_level(input int n, input int bound, input string nm);
    int k = 0;
    while (fifo_level != n && k < bound) begin
      tick();
      k++;
    end
    chk(nm, fifo_level, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    longint tv[7] = '{3276800, 16384, 16383, -16384, -16385, (64'sd1 <<< 39) - 1, -(64'sd1 <<< 39)};
    longint te[7] = '{100, 1, 0, 0, -1, 32767, -32768};
    bit     ts[7] = '{0, 0, 0, 0, 0, 1, 1};
    longint q, x, r64;
    bit     s;
    fir_sample_t pr;
    logic signed [AW-1:0] a;
    int g0, s0, d0;

    // Pin the model and the shared package function to hand-computed values.
    for (int i = 0; i < 7; i++) begin
      requant(tv[i], q, s);
      chk("model_data", q, te[i]);
      chk("model_sat", s, ts[i]);
      a  = tv[i][AW-1:0];
      pr = sat_round(a, SH);
      chk("pkg_data", pr.data, te[i]);
      chk("pkg_sat", pr.sat, ts[i]);
    end

    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_data", io.out_data, 0);
    rst_n = 1'b1;
    tick();

    // Basic scaling and latency.
    io.out_ready = 1'b1;
    s0 = sat_seen;
    send(3276800);
    tick();
    chk("lat_early_valid", io.out_valid, 0);
    tick();
    chk("lat_valid", io.out_valid, 1);
    chk("lat_data", io.out_data, 100);
    repeat (3) tick();
    chk("basic_no_sat", sat_seen - s0, 0);

    // Rounding edges.
    g0 = got.size();
    send(16384); send(16383); send(-16384); send(-16385);
    repeat (6) tick();
    chk("round_count", got.size() - g0, 4);
    chk("round_16384", got[g0], 1);
    chk("round_16383", got[g0+1], 0);
    chk("round_m16384", got[g0+2], 0);
    chk("round_m16385", got[g0+3], -1);

    // Saturation.
    g0 = got.size();
    s0 = sat_seen;
    send((64'sd1 <<< 39) - 1);
    send(-(64'sd1 <<< 39));
    repeat (6) tick();
    chk("sat_pos", got[g0], 32767);
    chk("sat_neg", got[g0+1], -32768);
    chk("sat_pulses", sat_seen - s0, 2);
`ifdef FIR_REQUANT_STATS_EN
    chk("sat_count_2", sat_count, 2);
`endif

    // Overflow: five strobes into a stalled four-entry buffer.
    io.out_ready = 1'b0;
    d0 = drop_seen;
    for (int v = 1; v <= 5; v++) send(longint'(v) * 32768);
    repeat (4) tick();
    chk("ovf_level", fifo_level, 4);
    chk("ovf_drops", drop_seen - d0, 1);
    g0 = got.size();
    io.out_ready = 1'b1;
    repeat (6) tick();
    chk("ovf_drain_count", got.size() - g0, 4);
    for (int v = 1; v <= 4; v++) chk("ovf_drain_order", got[g0+v-1], v);
    chk("ovf_empty", io.out_valid, 0);

    // Full buffer with a pop in the same cycle as a write.
    io.out_ready = 1'b0;
    for (int v = 10; v <= 13; v++) send(longint'(v) * 32768);
    wait_level(4, 10, "fp_fill");
    d0 = drop_seen;
    g0 = got.size();
    send(14 * 32768);
    tick();
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    chk("fp_level", fifo_level, 4);
    chk("fp_no_drop", drop_seen - d0, 0);
    io.out_ready = 1'b1;
    repeat (6) tick();
    chk("fp_count", got.size() - g0, 5);
    for (int v = 10; v <= 14; v++) chk("fp_order", got[g0+v-10], v);

    // Reset with three queued and two in flight.
    io.out_ready = 1'b0;
    for (int v = 21; v <= 23; v++) send(longint'(v) * 32768);
    wait_level(3, 10, "rst_fill");
    send(24 * 32768);
    send(25 * 32768);
    rst_n = 1'b0;
    tick();
    tick();
    chk("mid_rst_valid", io.out_valid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_data", io.out_data, 0);
    rst_n = 1'b1;
    g0 = got.size();
    s0 = sat_seen;
    d0 = drop_seen;
    io.out_ready = 1'b1;
    repeat (5) tick();
    chk("post_rst_nothing", got.size() - g0, 0);
    chk("post_rst_no_flags", (sat_seen - s0) + (drop_seen - d0), 0);
    send(7 * 32768);
    tick();
    chk("post_rst_early", io.out_valid, 0);
    tick();
    chk("post_rst_valid", io.out_valid, 1);
    chk("post_rst_data", io.out_data, 7);
    repeat (3) tick();

    // Random traffic with bursty consumer stalls.
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) io.out_ready = 1'b0;
      io.out_ready = ($urandom_range(0, 3) != 0) && ((i / 100) % 3 != 1);
      io.in_valid  = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 2))
        0: x = longint'(int'($urandom)) >>> $urandom_range(0, 8);
        1: begin
          r64 = {$urandom, $urandom};
          x   = r64 >>> $urandom_range(24, 40);
        end
        default: x = (longint'(int'($urandom_range(0, 2000))) - 1000) * 32768 + 16384
                     - longint'($urandom_range(0, 1));
      endcase
      io.in_data = x[AW-1:0];
`ifdef FIR_REQUANT_STATS_EN
      clr_stats = ($urandom_range(0, 199) == 0);
`endif
      tick();
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
`ifdef FIR_REQUANT_STATS_EN
    clr_stats = 1'b0;
`endif
    repeat (10) tick();
    chk("final_empty", io.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
